ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device receiver: synchronises and deglitches `ps2_clk`/`ps2_data`, deframes 11-bit PS/2 frames with an explicit state machine, and buffers validated scan-code bytes in a configurable-depth show-ahead FIFO. It supersedes the fixed 8-entry keyboard receiver in the Keyboard device path. It adds a pop handshake, an occupancy count, per-error pulses, clearable sticky overflow, and an optional frame-timeout watchdog. The CPU-side keyboard MMIO adapter consumes it.

## Interface
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal samples required before filtered `ps2_clk` changes; ≥1.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles mid-frame before abort; only used with `PS2_RX_TIMEOUT_EN`.
- `clk` in 1: system clock; one clock domain.
- `clrn` in 1: reset; asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `rd_en` in 1: pop head entry when `valid`.
- `clr_flags` in 1: clears sticky `overflow`.
- `data` out 8: FIFO head byte (show-ahead).
- `valid` out 1: FIFO non-empty.
- `level` out $clog2(FIFO_DEPTH)+1: entries held, 0..FIFO_DEPTH.
- `overflow` out 1: sticky; a completed byte was dropped because the FIFO was full.
- `err_parity` out 1: one-cycle pulse on a parity failure.
- `err_frame` out 1: one-cycle pulse on a bad stop bit or a timeout.

## Operation
- Two-flop synchronisers on both lines; reset value 1 (bus idle).
- Filter: the filtered clock takes the synchronised value after FILTER_LEN consecutive identical samples. Reset value 1.
- `sample` is a one-cycle pulse on the filtered clock's 1→0 transition. The synchronised `ps2_data`, delayed to align with the filter, is captured on `sample`.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on `sample` only.
  - IDLE: data=0 → DATA, bit counter=0. Data=1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB first. After 8 bits → PARITY.
  - PARITY: store the bit, then → STOP.
  - STOP: data=0 → `err_frame`. Otherwise, if XOR(data byte, parity) is 0 → `err_parity`. Otherwise push the byte. Always → IDLE. Framing error takes priority over parity error.
- FIFO push and pop rules:
  - Push when not full.
  - Push when full: the byte is dropped and `overflow` is set.
  - Pop when `rd_en && valid`. `rd_en` with `valid`=0 is ignored.
  - Push and pop in the same cycle while full: both take effect, no overflow, `level` unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
- Pointers wrap modulo FIFO_DEPTH. `level` is tracked separately so full and empty are unambiguous.
- `overflow` clears on `clr_flags` or reset. Set has priority over `clr_flags` in the same cycle.
- Reset values: `valid`, `level`, `overflow`, `err_parity`, `err_frame` = 0; FSM in IDLE; pointers 0. `data` is don't-care while `valid`=0. Reset mid-frame discards the partial frame; the next frame starts cleanly.

## Timing
- A stable raw `ps2_clk` fall produces `sample` exactly FILTER_LEN+3 `clk` cycles later.
- Stop-bit `sample` in cycle N: `valid`, `level` and `data` update in cycle N+1. Error pulses are high during cycle N+1 only.
- Pop in cycle N: the next head appears on `data` in cycle N+1.
- Glitches shorter than FILTER_LEN cycles on `ps2_clk` produce no `sample`.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A counter clears on every `sample` and counts while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE, the partial frame is discarded, and `err_frame` pulses for one cycle.
- Not defined: no counter is built, and a stalled frame waits indefinitely.

## Structure
- Package `ps2_pkg`:
  - enum `ps2_rx_state_t` (IDLE, DATA, PARITY, STOP);
  - constants `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11;
  - typedef `ps2_byte_t` (logic [7:0]).
- One sub-module `ps2_sync_fifo` (params WIDTH, DEPTH) implementing storage, pointers, `level`, the full-drop policy and overflow detection. The top level holds the synchronisers, filter, FSM and timeout.

## Test plan
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → `valid`=1, `data`=0x1C, `level`=1, no error pulses.
- Same frame with parity 1 → `err_parity` one-cycle pulse, `level` stays 0.
- Frame 0xF0 with stop bit 0 → `err_frame` pulse, nothing pushed.
- FIFO_DEPTH+1 good frames (0x01..0x09 for depth 8) with no pops → `level`=8, `overflow`=1, head 0x01, 0x09 dropped. `clr_flags` → `overflow`=0.
- 2-cycle low glitch on `ps2_clk` while in IDLE with FILTER_LEN=4 → no `sample`, state stays IDLE; a following valid frame is received intact.
- With `PS2_RX_TIMEOUT_EN`, TIMEOUT_CYCLES=100: send start bit plus 3 data bits, then hold `ps2_clk` high → `err_frame` pulse, FSM in IDLE. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: deframer state encoding, frame constants and parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

  // PS/2 uses odd parity: the eight data bits plus the parity bit hold an odd count of ones.
  function automatic logic ps2_parity_ok(input ps2_byte_t b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count, drop-on-full policy and sticky overflow.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clr_flags,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = DEPTH[AW:0];
  localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);

  // A pop frees the slot a simultaneous push needs, so full+push+pop is not a drop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid   = !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device receiver: line sync + clock deglitch, 11-bit frame deframer, byte FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  input  logic                        clr_flags,
  output logic [7:0]                  data,
  output logic                        valid,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        err_parity,
  output logic                        err_frame
);

  import ps2_pkg::*;

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FLT_ONE  = FW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic                clk_p0, clk_p1;
  logic                dat_p0, dat_p1;
  logic [FW-1:0]       flt_cnt;
  logic                clk_flt, clk_flt_d;
  logic                sample;
  logic [FILTER_LEN:0] dat_dly;
  logic                bit_in;

  ps2_rx_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  ps2_byte_t     sreg;
  logic          par;
  logic          push;
  logic          err_parity_n;
  logic          err_frame_n;
  logic          timeout;

  // Stage p0/p1: two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Filter stage: clock follows the synchroniser only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      sample    <= 1'b0;
    end else begin
      clk_flt_d <= clk_flt;
      sample    <= clk_flt_d & ~clk_flt;
      if (clk_p1 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_flt <= clk_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_ONE;
      end
    end
  end

  // Data delay matches the filter latency so bit_in is the value seen at the raw clock fall.
  always_ff @(posedge clk) begin
    dat_dly <= {dat_dly[FILTER_LEN-1:0], dat_p1};
  end

  assign bit_in = dat_dly[FILTER_LEN];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      to_cnt <= '0;
    end else if (sample || state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

  assign timeout = (state != IDLE) && !sample && (to_cnt == TO_LAST);
`else
  // Watchdog not built: the comparison is constant false for any legal parameter.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Deframer stage: state register and registered error pulses
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      err_parity <= err_parity_n;
      err_frame  <= err_frame_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    push         = 1'b0;
    err_parity_n = 1'b0;
    err_frame_n  = 1'b0;
    if (timeout) begin
      state_n     = IDLE;
      err_frame_n = 1'b1;
    end else if (sample) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) state_n = PARITY;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!bit_in)                         err_frame_n  = 1'b1;
          else if (!ps2_parity_ok(sreg, par))  err_parity_n = 1'b1;
          else                                 push         = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sample && state == DATA)   sreg <= {bit_in, sreg[PS2_DATA_BITS-1:1]};
    if (sample && state == PARITY) par  <= bit_in;
  end

  // FIFO stage
  ps2_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_data (sreg),
    .pop       (rd_en),
    .clr_flags (clr_flags),
    .rd_data   (data),
    .valid     (valid),
    .level     (level),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, monitor pops and checks bytes/error pulses.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int FLT   = 4;
  localparam int TO    = 100;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       clr_flags;
  logic [7:0] data;
  logic       valid;
  logic [3:0] level;
  logic       overflow;
  logic       err_parity;
  logic       err_frame;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_bytes[$];
  int         exp_errs[$];
  logic       drain_en = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .clr_flags  (clr_flags),
    .data       (data),
    .valid      (valid),
    .level      (level),
    .overflow   (overflow),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: error pulses (1 = parity, 2 = frame) and popped bytes against the queues.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (clrn) begin
        if (err_parity) begin
          if (exp_errs.size() == 0) check("unexpected err_parity", 1, 0);
          else check("err_parity kind", 1, exp_errs.pop_front());
        end
        if (err_frame) begin
          if (exp_errs.size() == 0) check("unexpected err_frame", 1, 0);
          else check("err_frame kind", 2, exp_errs.pop_front());
        end
        if (drain_en && valid) begin
          if (exp_bytes.size() == 0) check("unexpected byte", int'(data), -1);
          else check("popped byte", int'(data), int'(exp_bytes.pop_front()));
          rd_en = 1'b1;
        end
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF/2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF/2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((valid || exp_bytes.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_bytes.size(), 0);
  endtask

  initial begin
    clrn      = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    clr_flags = 1'b0;
    repeat (5) @(negedge clk);
    check("reset valid", valid, 0);
    check("reset level", level, 0);
    check("reset overflow", overflow, 0);
    check("reset err_parity", err_parity, 0);
    check("reset err_frame", err_frame, 0);
    clrn = 1'b1;
    repeat (10) @(negedge clk);

    // Good 0x1C frame, held in the FIFO
    exp_bytes.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("1C valid", valid, 1);
    check("1C data", int'(data), 'h1C);
    check("1C level", level, 1);
    check("1C overflow", overflow, 0);
    drain_en = 1'b1;
    wait_drain("1C drain");

    // Parity error
    exp_errs.push_back(1);
    send_frame(8'h1C, 1'b1, 1'b1);
    check("parity err seen", exp_errs.size(), 0);
    check("parity level", level, 0);

    // Bad stop bit
    exp_errs.push_back(2);
    send_frame(8'hF0, 1'b1, 1'b0);
    check("frame err seen", exp_errs.size(), 0);
    check("frame level", level, 0);

    // Overflow: DEPTH+1 frames with no pops, last one dropped
    drain_en = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) exp_bytes.push_back(8'(i));
      send_frame(8'(i), odd_par(8'(i)), 1'b1);
    end
    check("full level", level, DEPTH);
    check("full overflow", overflow, 1);
    check("full head", int'(data), 1);
    check("full valid", valid, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
    check("clr overflow", overflow, 0);
    check("clr level kept", level, DEPTH);
    drain_en = 1'b1;
    wait_drain("overflow drain");

    // Short low glitch with data low must not start a frame
    drain_en = 1'b0;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    check("glitch level", level, 0);
    exp_bytes.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("post-glitch level", level, 1);
    check("post-glitch data", int'(data), 'h5A);
    drain_en = 1'b1;
    wait_drain("glitch drain");

`ifdef PS2_RX_TIMEOUT_EN
    // Stalled frame: start + 3 data bits, then silence
    drain_en = 1'b0;
    exp_errs.push_back(2);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (3 * TO) @(negedge clk);
    check("timeout err seen", exp_errs.size(), 0);
    check("timeout level", level, 0);
    exp_bytes.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("post-timeout level", level, 1);
    check("post-timeout data", int'(data), 'h5A);
    drain_en = 1'b1;
    wait_drain("timeout drain");
`endif

    repeat (20) @(negedge clk);
    check("errors outstanding", exp_errs.size(), 0);
    check("final level", level, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
